// File: rtl/mmu_pkg.sv
// Shared constants for the load/store address translation pipeline:
// exception codes, DMW CSR field positions and translation mode encoding.
package mmu_pkg;

    localparam logic [5:0] ECODE_NONE = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam int unsigned DMW_PLV0    = 0;
    localparam int unsigned DMW_PLV3    = 3;
    localparam int unsigned DMW_MAT_LO  = 4;
    localparam int unsigned DMW_PSEG_LO = 25;
    localparam int unsigned DMW_VSEG_LO = 29;

    typedef enum logic [1:0] {
        MODE_DA  = 2'd0,
        MODE_DMW = 2'd1,
        MODE_TLB = 2'd2
    } mode_e;

endpackage

// File: rtl/mmu_dmw_match.sv
// Combinational match of one direct-mapped window against a VA segment and privilege level.
// Returns the hit flag plus the physical segment and MAT the window maps to.
module mmu_dmw_match (
    input  logic [31:0] dmw,
    input  logic [2:0]  va_seg,
    input  logic [1:0]  plv,
    output logic        hit,
    output logic [2:0]  pseg,
    output logic [1:0]  mat
);
    import mmu_pkg::*;

    logic plv_ok;
    logic unused_dmw;

    assign plv_ok = ((plv == 2'd0) & dmw[DMW_PLV0]) | ((plv == 2'd3) & dmw[DMW_PLV3]);
    assign hit    = (va_seg == dmw[DMW_VSEG_LO +: 3]) & plv_ok;
    assign pseg   = dmw[DMW_PSEG_LO +: 3];
    assign mat    = dmw[DMW_MAT_LO +: 2];

    assign unused_dmw = ^{dmw[2:1], dmw[24:6], dmw[28]};

endmodule

// File: rtl/mmu_xlate.sv
// Two-stage VA->PA translation for the load/store path: stage 1 registers the request and
// drives the TLB search, stage 2 registers PA/MAT/exception behind a valid/ready handshake.
module mmu_xlate #(
    parameter int unsigned PALEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_va,
    input  logic             req_store,
    input  logic             csr_da,
    input  logic             csr_pg,
    input  logic [1:0]       csr_plv,
    input  logic [1:0]       csr_datm,
    input  logic [9:0]       csr_asid,
    input  logic [31:0]      csr_dmw0,
    input  logic [31:0]      csr_dmw1,
    output logic [18:0]      tlb_vppn,
    output logic             tlb_va_bit12,
    output logic [9:0]       tlb_asid,
    input  logic             tlb_found,
    input  logic [19:0]      tlb_ppn,
    input  logic [5:0]       tlb_ps,
    input  logic [1:0]       tlb_plv,
    input  logic [1:0]       tlb_mat,
    input  logic             tlb_d,
    input  logic             tlb_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [PALEN-1:0] rsp_pa,
    output logic [1:0]       rsp_mat,
    output logic [31:0]      rsp_va,
    output logic             rsp_exc,
    output logic [5:0]       rsp_ecode
);
    import mmu_pkg::*;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_va_q;
    logic        s1_store_q;
    logic [1:0]  s1_plv_q;
    logic [9:0]  s1_asid_q;
    mode_e       s1_mode_q;
    logic [1:0]  s1_mat_q;
    logic [2:0]  s1_pseg_q;

    logic             rsp_valid_q, rsp_valid_d;
    logic [PALEN-1:0] rsp_pa_q;
    logic [1:0]       rsp_mat_q;
    logic [31:0]      rsp_va_q;
    logic             rsp_exc_q;
    logic [5:0]       rsp_ecode_q;

    logic adv1, adv2, accept, move;
    logic unused_pg;

    assign adv2      = !rsp_valid_q | rsp_ready;
    assign adv1      = !s1_valid_q | adv2;
    assign req_ready = !flush & adv1;
    assign accept    = req_valid & req_ready;
    assign move      = s1_valid_q & adv2 & !flush;
    // da=0 & pg=0 is architecturally illegal and simply falls through to TLB mode.
    assign unused_pg = csr_pg;

    // Mode decision on the incoming request, using CSRs as they are at acceptance.
    logic       dmw0_hit, dmw1_hit;
    logic [2:0] dmw0_pseg, dmw1_pseg;
    logic [1:0] dmw0_mat, dmw1_mat;
    mode_e      acc_mode;
    logic [1:0] acc_mat;
    logic [2:0] acc_pseg;

    mmu_dmw_match u_dmw0 (
        .dmw    (csr_dmw0),
        .va_seg (req_va[31:29]),
        .plv    (csr_plv),
        .hit    (dmw0_hit),
        .pseg   (dmw0_pseg),
        .mat    (dmw0_mat)
    );

    mmu_dmw_match u_dmw1 (
        .dmw    (csr_dmw1),
        .va_seg (req_va[31:29]),
        .plv    (csr_plv),
        .hit    (dmw1_hit),
        .pseg   (dmw1_pseg),
        .mat    (dmw1_mat)
    );

    always_comb begin
        acc_mode = MODE_TLB;
        acc_mat  = 2'b00;
        acc_pseg = 3'b000;
        if (csr_da) begin
            acc_mode = MODE_DA;
            acc_mat  = csr_datm;
        end else if (dmw0_hit) begin
            acc_mode = MODE_DMW;
            acc_mat  = dmw0_mat;
            acc_pseg = dmw0_pseg;
        end else if (dmw1_hit) begin
            acc_mode = MODE_DMW;
            acc_mat  = dmw1_mat;
            acc_pseg = dmw1_pseg;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q & !flush;
        if (adv1) begin
            s1_valid_d = accept;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_va_q    <= '0;
            s1_store_q <= 1'b0;
            s1_plv_q   <= '0;
            s1_asid_q  <= '0;
            s1_mode_q  <= MODE_DA;
            s1_mat_q   <= '0;
            s1_pseg_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_va_q    <= req_va;
                s1_store_q <= req_store;
                s1_plv_q   <= csr_plv;
                s1_asid_q  <= csr_asid;
                s1_mode_q  <= acc_mode;
                s1_mat_q   <= acc_mat;
                s1_pseg_q  <= acc_pseg;
            end
        end
    end

    assign tlb_vppn     = s1_va_q[31:13];
    assign tlb_va_bit12 = s1_va_q[12];
    assign tlb_asid     = s1_asid_q;

    // Stage-2 result; a faulting access reports PA and MAT as zero.
    logic [PALEN-1:0] res_pa;
    logic [1:0]       res_mat;
    logic [5:0]       res_ecode;

    always_comb begin
        res_pa    = '0;
        res_mat   = 2'b00;
        res_ecode = ECODE_NONE;
        case (s1_mode_q)
            MODE_DA: begin
                res_pa  = s1_va_q;
                res_mat = s1_mat_q;
            end
            MODE_DMW: begin
                res_pa  = {s1_pseg_q, s1_va_q[28:0]};
                res_mat = s1_mat_q;
            end
            default: begin
                if (!tlb_found) begin
                    res_ecode = ECODE_TLBR;
                end else if (!tlb_v) begin
                    res_ecode = s1_store_q ? ECODE_PIS : ECODE_PIL;
                end else if (s1_plv_q > tlb_plv) begin
                    res_ecode = ECODE_PPI;
                end else if (s1_store_q & !tlb_d) begin
                    res_ecode = ECODE_PME;
                end else begin
                    res_mat = tlb_mat;
                    res_pa  = (tlb_ps == 6'd22) ? {tlb_ppn[19:10], s1_va_q[21:0]}
                                                : {tlb_ppn, s1_va_q[11:0]};
                end
            end
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (adv2) begin
            rsp_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_pa_q    <= '0;
            rsp_mat_q   <= '0;
            rsp_va_q    <= '0;
            rsp_exc_q   <= 1'b0;
            rsp_ecode_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (move) begin
                rsp_pa_q    <= res_pa;
                rsp_mat_q   <= res_mat;
                rsp_va_q    <= s1_va_q;
                rsp_exc_q   <= (res_ecode != ECODE_NONE);
                rsp_ecode_q <= res_ecode;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_pa    = rsp_pa_q;
    assign rsp_mat   = rsp_mat_q;
    assign rsp_va    = rsp_va_q;
    assign rsp_exc   = rsp_exc_q;
    assign rsp_ecode = rsp_ecode_q;

endmodule

// File: tb/tb_mmu_xlate.sv
// Bench for mmu_xlate: directed cases with hand-computed results, then randomized traffic
// scored against a behavioural translation model backed by a small bench-side TLB.
module tb_mmu_xlate;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_va;
    logic        req_store;
    logic        csr_da, csr_pg;
    logic [1:0]  csr_plv, csr_datm;
    logic [9:0]  csr_asid;
    logic [31:0] csr_dmw0, csr_dmw1;
    logic [18:0] tlb_vppn;
    logic        tlb_va_bit12;
    logic [9:0]  tlb_asid;
    logic        tlb_found;
    logic [19:0] tlb_ppn;
    logic [5:0]  tlb_ps;
    logic [1:0]  tlb_plv, tlb_mat;
    logic        tlb_d, tlb_v;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_pa;
    logic [1:0]  rsp_mat;
    logic [31:0] rsp_va;
    logic        rsp_exc;
    logic [5:0]  rsp_ecode;

    mmu_xlate #(.PALEN(32)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_va       (req_va),
        .req_store    (req_store),
        .csr_da       (csr_da),
        .csr_pg       (csr_pg),
        .csr_plv      (csr_plv),
        .csr_datm     (csr_datm),
        .csr_asid     (csr_asid),
        .csr_dmw0     (csr_dmw0),
        .csr_dmw1     (csr_dmw1),
        .tlb_vppn     (tlb_vppn),
        .tlb_va_bit12 (tlb_va_bit12),
        .tlb_asid     (tlb_asid),
        .tlb_found    (tlb_found),
        .tlb_ppn      (tlb_ppn),
        .tlb_ps       (tlb_ps),
        .tlb_plv      (tlb_plv),
        .tlb_mat      (tlb_mat),
        .tlb_d        (tlb_d),
        .tlb_v        (tlb_v),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_pa       (rsp_pa),
        .rsp_mat      (rsp_mat),
        .rsp_va       (rsp_va),
        .rsp_exc      (rsp_exc),
        .rsp_ecode    (rsp_ecode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rsp    = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bench-side TLB: each entry maps one 4 KiB or 4 MiB page for one ASID.
    typedef struct packed {
        logic        present;
        logic [9:0]  asid;
        logic [19:0] vtag;   // va[31:12] of the page
        logic [5:0]  ps;
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlbe_t;

    tlbe_t tlb_tab [4];

    function automatic tlbe_t tlb_lookup(input logic [31:0] va, input logic [9:0] asid);
        tlbe_t       r;
        logic [31:0] page;
        logic        hit;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            page = {12'h000, tlb_tab[i].vtag};
            hit  = (tlb_tab[i].ps == 6'd22) ? ((va >> 22) == (page >> 10)) : ((va >> 12) == page);
            if (!r.present && tlb_tab[i].present && tlb_tab[i].asid == asid && hit) r = tlb_tab[i];
        end
        return r;
    endfunction

    tlbe_t hit_e;
    always_comb begin
        hit_e        = tlb_lookup({tlb_vppn, tlb_va_bit12, 12'h000}, tlb_asid);
        tlb_found    = hit_e.present;
        tlb_ppn      = hit_e.ppn;
        tlb_ps       = hit_e.ps;
        tlb_plv      = hit_e.plv;
        tlb_mat      = hit_e.mat;
        tlb_d        = hit_e.d;
        tlb_v        = hit_e.v;
    end

    typedef struct packed {
        logic [31:0] pa;
        logic [1:0]  mat;
        logic        exc;
        logic [5:0]  ecode;
        logic [31:0] va;
    } exp_t;

    function automatic logic dmw_hits(input logic [31:0] w, input logic [31:0] va,
                                      input logic [1:0] plv);
        return ((va >> 29) == (w >> 29)) && ((plv == 2'd0 && w[0]) || (plv == 2'd3 && w[3]));
    endfunction

    function automatic exp_t model(input logic [31:0] va, input logic st, input logic da,
                                   input logic [1:0] plv, input logic [1:0] datm,
                                   input logic [9:0] asid, input logic [31:0] w0,
                                   input logic [31:0] w1);
        exp_t        r;
        tlbe_t       e;
        logic [31:0] ppn32;
        r    = '0;
        r.va = va;
        if (da) begin
            r.pa  = va;
            r.mat = datm;
        end else if (dmw_hits(w0, va, plv)) begin
            r.pa  = {w0[27:25], 29'h0} + (va & 32'h1FFF_FFFF);
            r.mat = w0[5:4];
        end else if (dmw_hits(w1, va, plv)) begin
            r.pa  = {w1[27:25], 29'h0} + (va & 32'h1FFF_FFFF);
            r.mat = w1[5:4];
        end else begin
            e     = tlb_lookup(va, asid);
            ppn32 = {12'h000, e.ppn};
            if (!e.present)            r.ecode = 6'h3F;
            else if (!e.v)             r.ecode = st ? 6'h02 : 6'h01;
            else if (plv > e.plv)      r.ecode = 6'h07;
            else if (st && !e.d)       r.ecode = 6'h04;
            else begin
                r.mat = e.mat;
                if (e.ps == 6'd22) r.pa = (ppn32 >> 10) * 32'h0040_0000 + (va % 32'h0040_0000);
                else               r.pa = ppn32 * 32'h0000_1000 + (va % 32'h0000_1000);
            end
            r.exc = (r.ecode != 6'h00);
        end
        return r;
    endfunction

    // Scoreboard: expectations enter at acceptance, the oldest is compared whenever a result shows.
    exp_t exp_q [$];
    exp_t got_m;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (rsp_valid) begin
                got_m = {rsp_pa, rsp_mat, rsp_exc, rsp_ecode, rsp_va};
                if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 1'b0);
                else begin
                    check("rsp", got_m, exp_q[0]);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        n_rsp++;
                    end
                end
            end
            if (flush) exp_q.delete();
            else if (req_valid && req_ready)
                exp_q.push_back(model(req_va, req_store, csr_da, csr_plv, csr_datm, csr_asid,
                                      csr_dmw0, csr_dmw1));
        end
    end

    task automatic set_entry(input int i, input logic [9:0] asid, input logic [19:0] vtag,
                             input logic [5:0] ps, input logic [19:0] ppn, input logic [1:0] plv,
                             input logic [1:0] mat, input logic d, input logic v);
        tlb_tab[i] = '{present: 1'b1, asid: asid, vtag: vtag, ps: ps, ppn: ppn, plv: plv,
                       mat: mat, d: d, v: v};
    endtask

    task automatic clear_tlb();
        for (int i = 0; i < 4; i++) tlb_tab[i] = '0;
    endtask

    // One isolated request with hand-computed expectations and latency checks.
    task automatic xlate(input string tag, input logic [31:0] va, input logic st,
                         input logic [31:0] e_pa, input logic [1:0] e_mat, input logic [5:0] e_ec);
        @(posedge clk); #1;
        req_valid = 1'b1; req_va = va; req_store = st; rsp_ready = 1'b1; flush = 1'b0;
        @(negedge clk); check({tag, "_ready"}, req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); check({tag, "_lat1"}, rsp_valid, 1'b0);
        @(negedge clk); check({tag, "_lat2"}, rsp_valid, 1'b1);
        check({tag, "_pa"}, rsp_pa, e_pa);
        check({tag, "_mat"}, rsp_mat, e_mat);
        check({tag, "_exc"}, rsp_exc, (e_ec != 6'h00));
        check({tag, "_ecode"}, rsp_ecode, e_ec);
        @(negedge clk); check({tag, "_lat3"}, rsp_valid, 1'b0);
    endtask

    task automatic drain(input string tag);
        int budget;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        budget = 0;
        while ((exp_q.size() != 0 || rsp_valid) && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check({tag, "_drained"}, {rsp_valid, exp_q.size() != 0}, 2'b00);
    endtask

    task automatic rand_cycle();
        int k;
        @(posedge clk); #1;
        k         = $urandom_range(3);
        req_valid = ($urandom_range(3) != 0);
        req_store = 1'($urandom_range(1));
        if ($urandom_range(1) == 1) begin
            req_va   = {tlb_tab[k].vtag, 12'($urandom)};
            csr_asid = tlb_tab[k].asid;
        end else begin
            req_va   = $urandom;
            csr_asid = 10'($urandom_range(3));
        end
        csr_da    = ($urandom_range(7) == 0);
        csr_pg    = 1'($urandom_range(1));
        csr_plv   = 2'($urandom_range(3));
        csr_datm  = 2'($urandom_range(3));
        csr_dmw0  = $urandom;
        csr_dmw1  = $urandom;
        if ($urandom_range(3) == 0) csr_dmw0[31:29] = req_va[31:29];
        if ($urandom_range(3) == 0) csr_dmw1[31:29] = req_va[31:29];
        rsp_ready = ($urandom_range(9) < 7);
        flush     = ($urandom_range(19) == 0);
    endtask

    task automatic rand_tlb();
        for (int i = 0; i < 4; i++) begin
            tlb_tab[i] = '{present: ($urandom_range(4) != 0), asid: 10'($urandom_range(3)),
                           vtag: 20'($urandom), ps: ($urandom_range(1) == 1) ? 6'd22 : 6'd12,
                           ppn: 20'($urandom), plv: 2'($urandom_range(3)),
                           mat: 2'($urandom_range(3)), d: ($urandom_range(3) != 0),
                           v: ($urandom_range(3) != 0)};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at 1000000, required to have finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent, n0;
        logic acc;
        logic [31:0] vas [4];

        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_va = '0; req_store = 1'b0;
        csr_da = 1'b0; csr_pg = 1'b1; csr_plv = '0; csr_datm = '0; csr_asid = '0;
        csr_dmw0 = '0; csr_dmw1 = '0; rsp_ready = 1'b1;
        clear_tlb();
        #12;
        check("reset_state", {rsp_valid, rsp_pa, rsp_mat, rsp_va, rsp_exc, rsp_ecode,
                              tlb_vppn, tlb_va_bit12, tlb_asid}, '0);
        @(posedge clk); #1 reset = 1'b0;

        // Direct mode.
        csr_da = 1'b1; csr_datm = 2'd1;
        xlate("da", 32'h1234_5678, 1'b0, 32'h1234_5678, 2'd1, 6'h00);

        // DMW windows, DMW0 priority, privilege miss falling back to TLB mode.
        csr_da = 1'b0; csr_plv = 2'd0; csr_dmw0 = 32'hA000_0011;
        xlate("dmw0", 32'hA000_1000, 1'b0, 32'h0000_1000, 2'd1, 6'h00);
        csr_dmw1 = 32'hA200_0021;
        xlate("dmw_prio", 32'hA000_1000, 1'b1, 32'h0000_1000, 2'd1, 6'h00);
        csr_dmw0 = 32'h0;
        xlate("dmw1", 32'hA000_1000, 1'b0, 32'h2000_1000, 2'd2, 6'h00);
        csr_dmw0 = 32'hA000_0011; csr_dmw1 = 32'h0; csr_plv = 2'd3;
        xlate("dmw_plv3_tlbr", 32'hA000_1000, 1'b0, 32'h0, 2'd0, 6'h3F);

        // Page-table translation and exception priority.
        csr_dmw0 = 32'h0; csr_plv = 2'd0; csr_asid = 10'd5;
        set_entry(0, 10'd5, 20'h0ABCD, 6'd22, 20'h12345, 2'd3, 2'd2, 1'b1, 1'b1);
        xlate("tlb_ps22", 32'h0ABC_DEF0, 1'b0, 32'h123C_DEF0, 2'd2, 6'h00);
        set_entry(0, 10'd5, 20'h0ABCD, 6'd12, 20'h12345, 2'd3, 2'd2, 1'b1, 1'b1);
        xlate("tlb_ps12", 32'h0ABC_DEF0, 1'b1, 32'h1234_5EF0, 2'd2, 6'h00);
        csr_asid = 10'd6;
        xlate("tlb_asid_miss", 32'h0ABC_DEF0, 1'b0, 32'h0, 2'd0, 6'h3F);
        csr_asid = 10'd5;
        set_entry(0, 10'd5, 20'h0ABCD, 6'd12, 20'h12345, 2'd0, 2'd2, 1'b0, 1'b0);
        xlate("pis", 32'h0ABC_DEF0, 1'b1, 32'h0, 2'd0, 6'h02);
        xlate("pil", 32'h0ABC_DEF0, 1'b0, 32'h0, 2'd0, 6'h01);
        set_entry(0, 10'd5, 20'h0ABCD, 6'd12, 20'h12345, 2'd0, 2'd2, 1'b0, 1'b1);
        csr_plv = 2'd3;
        xlate("ppi", 32'h0ABC_DEF0, 1'b1, 32'h0, 2'd0, 6'h07);
        csr_plv = 2'd0;
        xlate("pme", 32'h0ABC_DEF0, 1'b1, 32'h0, 2'd0, 6'h04);
        xlate("clean_load", 32'h0ABC_DEF0, 1'b0, 32'h1234_5EF0, 2'd2, 6'h00);

        // Back-to-back requests against a consumer stalled for three cycles.
        csr_da = 1'b1; csr_datm = 2'd2;
        vas[0] = 32'h0000_0100; vas[1] = 32'h0000_0200; vas[2] = 32'h0000_0300;
        vas[3] = 32'h0000_0400;
        n0 = n_rsp; sent = 0;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b1; req_va = vas[0];
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (cyc == 2) check("b2b_full_ready", req_ready, 1'b0);
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            if (sent >= 4) req_valid = 1'b0;
            else req_va = vas[sent];
            rsp_ready = (cyc >= 2);
        end
        check("b2b_count", 32'(n_rsp - n0), 32'd4);
        drain("b2b");

        // Flush with both stages full and a request waiting.
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b1; req_va = 32'h0000_0A00;
        @(posedge clk); #1 req_va = 32'h0000_0B00;
        @(posedge clk); #1;
        req_va = 32'h0000_0C00; flush = 1'b1;
        @(negedge clk); check("flush_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk); check("flush_rsp", rsp_valid, 1'b0);
        @(negedge clk); check("flush_s1_killed", rsp_valid, 1'b0);
        @(negedge clk); check("flush_no_accept", rsp_valid, 1'b0);

        // Asynchronous reset in the middle of traffic.
        csr_asid = 10'h155;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b1; req_va = 32'hDEAD_B000;
        @(posedge clk); #1 req_va = 32'hCAFE_F000;
        @(posedge clk); #3 reset = 1'b1;
        req_valid = 1'b0;
        #1;
        check("reset_async", {rsp_valid, rsp_pa, rsp_mat, rsp_va, rsp_exc, rsp_ecode,
                              tlb_vppn, tlb_va_bit12, tlb_asid}, '0);
        @(posedge clk); #1 reset = 1'b0;
        rsp_ready = 1'b1;

        // Randomized traffic; the TLB contents only change while the pipe is empty.
        for (int b = 0; b < 10; b++) begin
            rand_tlb();
            for (int c = 0; c < 40; c++) rand_cycle();
            drain("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
